// File: rtl/if_ctrl.sv
// rtl/if_ctrl.sv - instruction fetch controller feeding a one-entry decode slot
// Optional 1-entry skid buffer for 1 instr/cycle throughput: define FETCH_SKID_EN.
module if_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_addr_i,
  input  logic        stall_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] fetch_cnt_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic        consume;
  logic        ready;
  logic        unused_baddr_lsb;

`ifdef FETCH_SKID_EN
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
`endif

  assign mem_req_o        = (state_q == REQ) || (state_q == DROP);
  assign ready            = mem_req_o && mem_ready_i;
  assign consume          = valid_q && !stall_i && !branch_flag_i;
  assign unused_baddr_lsb = ^branch_addr_i[1:0];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;
`ifdef FETCH_SKID_EN
    skid_v_d    = skid_v_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
`endif

    if (consume) begin
      cnt_d   = cnt_q + 32'd1;
      valid_d = 1'b0;
    end
`ifdef FETCH_SKID_EN
    if (consume && skid_v_q) begin
      valid_d  = 1'b1;
      inst_d   = skid_inst_q;
      pc_d     = skid_pc_q;
      skid_v_d = 1'b0;
    end
`endif

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (ready) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
`ifdef FETCH_SKID_EN
          // valid_d is already low when the slot was empty or is being consumed
          if (!valid_d) begin
            valid_d = 1'b1;
            inst_d  = mem_data_i;
            pc_d    = fetch_pc_q;
          end else begin
            skid_v_d    = 1'b1;
            skid_inst_d = mem_data_i;
            skid_pc_d   = fetch_pc_q;
          end
          state_d = skid_v_d ? WAIT : REQ;
`else
          valid_d = 1'b1;
          inst_d  = mem_data_i;
          pc_d    = fetch_pc_q;
          state_d = WAIT;
`endif
        end
      end
      WAIT: begin
`ifdef FETCH_SKID_EN
        if (!skid_v_d) state_d = REQ;
`else
        if (consume) state_d = REQ;
`endif
      end
      DROP: if (ready) state_d = REQ;
      default: state_d = IDLE;
    endcase

    if (branch_flag_i) begin
      valid_d    = 1'b0;
`ifdef FETCH_SKID_EN
      skid_v_d   = 1'b0;
`endif
      fetch_pc_d = {branch_addr_i[31:2], 2'b00};
      state_d    = (mem_req_o && !mem_ready_i) ? DROP : REQ;
    end

    // an outstanding request in DROP keeps its original address until ready
    addr_d = (state_d == DROP) ? addr_q : fetch_pc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= 32'h0;
      inst_q     <= 32'h0;
      pc_q       <= 32'h0;
      valid_q    <= 1'b0;
      cnt_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef FETCH_SKID_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_v_q    <= 1'b0;
      skid_inst_q <= 32'h0;
      skid_pc_q   <= 32'h0;
    end else begin
      skid_v_q    <= skid_v_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
    end
  end
`endif

  assign mem_addr_o   = addr_q;
  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign pc_o         = pc_q;
  assign fetch_cnt_o  = cnt_q;

endmodule
